// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions for the hazard controller.
// Holds the hazard FSM state type, the load result-select encoding and the
// width of the memory wait counter (sized for MEM_TIMEOUT up to 255).
package pipeline_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        MEM_ERR  = 2'd2
    } hazard_state_t;

    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

    localparam int WAIT_CNT_W = 8;

endpackage : pipeline_pkg

// File: rtl/hazard_perf_cnt.sv
// Saturating enable counter used for the hazard performance counters.
// Counts once per enabled cycle and sticks at all-ones.
module hazard_perf_cnt #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [WIDTH-1:0] cnt
);

    // Count enabled cycles, holding at all-ones once saturated.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: flops take non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            cnt <= '0;
        end else if (en && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule : hazard_perf_cnt

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory-wait stalls with timeout, load-use
// stalls and branch flushes. All stall/flush outputs are combinational.
// Optional performance counters are built only with HAZARD_CTRL_PERF_EN
// defined; otherwise stall_cnt/flush_cnt are tied to zero.
module hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int REG_LENGTH  = 5,
    parameter int MEM_TIMEOUT = 15,
    parameter int PERF_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_LENGTH-1:0] rs1_d,
    input  logic [REG_LENGTH-1:0] rs2_d,
    input  logic [REG_LENGTH-1:0] rd_e,
    input  logic [1:0]            result_src_e,
    input  logic                  pc_src_e,
    input  logic                  mem_req_m,
    input  logic                  mem_ack,
    output logic                  stall_f,
    output logic                  stall_d,
    output logic                  stall_e,
    output logic                  stall_m,
    output logic                  flush_d,
    output logic                  flush_e,
    output logic                  flush_w,
    output logic                  mem_err,
    output logic [PERF_WIDTH-1:0] stall_cnt,
    output logic [PERF_WIDTH-1:0] flush_cnt
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(MEM_TIMEOUT - 1);

    hazard_state_t         state;
    hazard_state_t         state_nxt;
    logic [WAIT_CNT_W-1:0] wait_cnt;
    logic [WAIT_CNT_W-1:0] wait_cnt_nxt;
    logic                  mem_stall;
    logic                  resp_en;
    logic                  branch;
    logic                  load_use;

    // State and wait-counter registers; mem_err latches on entry to MEM_ERR.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= RUN;
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (state_nxt == MEM_ERR) begin
                mem_err <= 1'b1;
            end
        end
    end

    // Next-state logic and memory-stall decode.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        mem_stall    = 1'b0;
        unique case (state)
            RUN: begin
                if (mem_req_m && !mem_ack) begin
                    mem_stall    = 1'b1;
                    state_nxt    = MEM_WAIT;
                    wait_cnt_nxt = '0;
                end
            end
            MEM_WAIT: begin
                if (mem_ack) begin
                    state_nxt = RUN;
                end else begin
                    mem_stall = 1'b1;
                    if (wait_cnt == WAIT_LAST) begin
                        state_nxt = MEM_ERR;
                    end else begin
                        wait_cnt_nxt = wait_cnt + 1'b1;
                    end
                end
            end
            MEM_ERR: begin
                // Terminal until reset; the ack is deliberately ignored here.
                mem_stall = 1'b1;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    // Branch and load-use responses; suppressed while memory holds the pipe.
    // The ack cycle of MEM_WAIT releases the pipe, so a frozen branch or
    // load-use in EX is acted on in that same cycle.
    always_comb begin
        resp_en  = rst && !mem_stall;
        branch   = resp_en && pc_src_e;
        load_use = resp_en && !pc_src_e
                   && (result_src_e == RESULT_SRC_LOAD)
                   && (rd_e != '0)
                   && ((rd_e == rs1_d) || (rd_e == rs2_d));
    end

    // Output decode; everything is forced low while reset is asserted.
    always_comb begin
        stall_f = (rst && mem_stall) || load_use;
        stall_d = (rst && mem_stall) || load_use;
        stall_e = rst && mem_stall;
        stall_m = rst && mem_stall;
        flush_w = rst && mem_stall;
        flush_d = branch;
        flush_e = branch || load_use;
    end

`ifdef HAZARD_CTRL_PERF_EN
    hazard_perf_cnt #(
        .WIDTH (PERF_WIDTH)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst),
        .en    (stall_f),
        .cnt   (stall_cnt)
    );

    hazard_perf_cnt #(
        .WIDTH (PERF_WIDTH)
    ) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst),
        .en    (flush_d),
        .cnt   (flush_cnt)
    );
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule : hazard_ctrl
